// File: rtl/rgb_wb_pkg.sv
// Shared constants for the RGB white-balance stage: register map, packet type
// code and the fixed-point constants used by the per-channel multipliers.
package rgb_wb_pkg;

   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_STATUS    = 3'd1;
   localparam logic [2:0] ADDR_GAIN_R    = 3'd2;
   localparam logic [2:0] ADDR_GAIN_G    = 3'd3;
   localparam logic [2:0] ADDR_GAIN_B    = 3'd4;
   localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;

   localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

   localparam int GAIN_ONE = 'h100;
   localparam int ROUND    = 'h80;

endpackage

// File: rtl/rgb_white_balance_mul.sv
// One colour channel: stage 1 registers pixel*gain plus the rounding constant,
// stage 2 drops the 8 fraction bits and saturates, or passes the raw pixel.
module wb_channel_mul
   import rgb_wb_pkg::*;
#(
   parameter int DW     = 8,
   parameter int GAIN_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              mod_i,
   input  logic [DW-1:0]     pix_i,
   input  logic [GAIN_W-1:0] gain_i,
   output logic [DW-1:0]     pix_o
);

   localparam int PW   = DW + GAIN_W;
   localparam int FRAC = 8;
   localparam int QW   = PW - FRAC;

   logic [PW-1:0] sum_p1_d, sum_p1_q;
   logic [DW-1:0] raw_p1_q;
   logic          mod_p1_q;
   logic [DW-1:0] pix_p2_d, pix_p2_q;

   function automatic logic [DW-1:0] shift_sat(input logic [PW-1:0] sum);
      logic [QW-1:0] q;
      q = sum[PW-1:FRAC];
      if (q > QW'((1 << DW) - 1)) begin
         shift_sat = {DW{1'b1}};
      end else begin
         shift_sat = q[DW-1:0];
      end
   endfunction

   assign sum_p1_d = PW'(pix_i) * PW'(gain_i) + PW'(ROUND);
   assign pix_p2_d = mod_p1_q ? shift_sat(sum_p1_q) : raw_p1_q;

   // stage 1 -> stage 2 boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_p1_q <= '0;
         raw_p1_q <= '0;
         mod_p1_q <= 1'b0;
         pix_p2_q <= '0;
      end else if (en_i) begin
         sum_p1_q <= sum_p1_d;
         raw_p1_q <= pix_i;
         mod_p1_q <= mod_i;
         pix_p2_q <= pix_p2_d;
      end
   end

   assign pix_o = pix_p2_q;

endmodule

// File: rtl/rgb_white_balance.sv
// Avalon-ST RGB white balance: per-channel gains applied to video pixel beats,
// gains latched at each video sop, programmed through a small Avalon-MM slave.
module rgb_white_balance
   import rgb_wb_pkg::*;
#(
   parameter int DW     = 8,
   parameter int GAIN_W = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3*DW-1:0] sink_data,
   input  logic            sink_sop,
   input  logic            sink_eop,
   input  logic            sink_valid,
   output logic            sink_ready,
   output logic [3*DW-1:0] source_data,
   output logic            source_sop,
   output logic            source_eop,
   output logic            source_valid,
   input  logic            source_ready,
   input  logic [2:0]      slave_addr,
   input  logic            slave_write,
   input  logic [31:0]     slave_writedata,
   input  logic            slave_read,
   output logic [31:0]     slave_readdata
);

   logic              en, accept, is_video_sop, beat_mod, beat_vid, out_fire, err_clr;
   logic              go_q, bypass_q;
   logic              in_packet_d, in_packet_q, is_video_d, is_video_q;
   logic              byp_act_d, byp_act_q, sop_err_d, sop_err_q;
   logic [GAIN_W-1:0] gain_r_q, gain_g_q, gain_b_q;
   logic [GAIN_W-1:0] act_r_q, act_g_q, act_b_q;
   logic [15:0]       frame_cnt_d, frame_cnt_q;
   logic [31:0]       readdata_d, readdata_q;
   logic              vld_p1_q, sop_p1_q, eop_p1_q, vid_p1_q;
   logic              vld_p2_q, sop_p2_q, eop_p2_q, vid_p2_q;
   logic              unused_wdata;

   assign unused_wdata = ^slave_writedata[31:GAIN_W];

   assign en           = !vld_p2_q || source_ready;
   assign sink_ready   = en && (in_packet_q || go_q);
   assign accept       = sink_valid && sink_ready;
   assign is_video_sop = (sink_data[3:0] == PKT_TYPE_VIDEO);
   // Header beats and beats outside a known video packet are never modified.
   assign beat_mod     = !sink_sop && in_packet_q && is_video_q && !byp_act_q;
   assign beat_vid     = sink_sop ? is_video_sop : (in_packet_q && is_video_q);
   assign out_fire     = vld_p2_q && source_ready;
   assign err_clr      = slave_write && (slave_addr == ADDR_STATUS) && slave_writedata[1];

   always_comb begin
      in_packet_d = in_packet_q;
      is_video_d  = is_video_q;
      byp_act_d   = byp_act_q;
      if (accept) begin
         if (sink_sop) begin
            in_packet_d = !sink_eop;
            is_video_d  = is_video_sop;
            if (is_video_sop) begin
               byp_act_d = bypass_q;
            end
         end else if (sink_eop) begin
            in_packet_d = 1'b0;
         end
      end
   end

   assign sop_err_d   = (sop_err_q && !err_clr) || (accept && sink_sop && in_packet_q);
   assign frame_cnt_d = frame_cnt_q + 16'(out_fire && eop_p2_q && vid_p2_q);

   always_comb begin
      readdata_d = '0;
      case (slave_addr)
         ADDR_CTRL:      readdata_d = {30'd0, bypass_q, go_q};
         ADDR_STATUS:    readdata_d = {30'd0, sop_err_q, in_packet_q};
         ADDR_GAIN_R:    readdata_d = 32'(gain_r_q);
         ADDR_GAIN_G:    readdata_d = 32'(gain_g_q);
         ADDR_GAIN_B:    readdata_d = 32'(gain_b_q);
         ADDR_FRAME_CNT: readdata_d = {16'd0, frame_cnt_q};
         default:        readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_q        <= 1'b0;
         bypass_q    <= 1'b0;
         gain_r_q    <= GAIN_W'(GAIN_ONE);
         gain_g_q    <= GAIN_W'(GAIN_ONE);
         gain_b_q    <= GAIN_W'(GAIN_ONE);
         act_r_q     <= GAIN_W'(GAIN_ONE);
         act_g_q     <= GAIN_W'(GAIN_ONE);
         act_b_q     <= GAIN_W'(GAIN_ONE);
         in_packet_q <= 1'b0;
         is_video_q  <= 1'b0;
         byp_act_q   <= 1'b0;
         sop_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         readdata_q  <= '0;
      end else begin
         in_packet_q <= in_packet_d;
         is_video_q  <= is_video_d;
         byp_act_q   <= byp_act_d;
         sop_err_q   <= sop_err_d;
         frame_cnt_q <= frame_cnt_d;
         // Active gains only move at a video sop, so a frame never mixes gain sets.
         if (accept && sink_sop && is_video_sop) begin
            act_r_q <= gain_r_q;
            act_g_q <= gain_g_q;
            act_b_q <= gain_b_q;
         end
         if (slave_write) begin
            case (slave_addr)
               ADDR_CTRL: begin
                  go_q     <= slave_writedata[0];
                  bypass_q <= slave_writedata[1];
               end
               ADDR_GAIN_R: gain_r_q <= slave_writedata[GAIN_W-1:0];
               ADDR_GAIN_G: gain_g_q <= slave_writedata[GAIN_W-1:0];
               ADDR_GAIN_B: gain_b_q <= slave_writedata[GAIN_W-1:0];
               default: ;
            endcase
         end
         if (slave_read) begin
            readdata_q <= readdata_d;
         end
      end
   end

   // input -> stage 1 -> stage 2 boundaries (control side)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         sop_p1_q <= 1'b0;
         eop_p1_q <= 1'b0;
         vid_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         sop_p2_q <= 1'b0;
         eop_p2_q <= 1'b0;
         vid_p2_q <= 1'b0;
      end else if (en) begin
         vld_p1_q <= accept;
         sop_p1_q <= accept && sink_sop;
         eop_p1_q <= accept && sink_eop;
         vid_p1_q <= accept && beat_vid;
         vld_p2_q <= vld_p1_q;
         sop_p2_q <= sop_p1_q;
         eop_p2_q <= eop_p1_q;
         vid_p2_q <= vid_p1_q;
      end
   end

   wb_channel_mul #(.DW(DW), .GAIN_W(GAIN_W)) u_mul_r (
      .clk(clk), .rst_n(rst_n), .en_i(en), .mod_i(beat_mod),
      .pix_i(sink_data[3*DW-1:2*DW]), .gain_i(act_r_q), .pix_o(source_data[3*DW-1:2*DW])
   );

   wb_channel_mul #(.DW(DW), .GAIN_W(GAIN_W)) u_mul_g (
      .clk(clk), .rst_n(rst_n), .en_i(en), .mod_i(beat_mod),
      .pix_i(sink_data[2*DW-1:DW]), .gain_i(act_g_q), .pix_o(source_data[2*DW-1:DW])
   );

   wb_channel_mul #(.DW(DW), .GAIN_W(GAIN_W)) u_mul_b (
      .clk(clk), .rst_n(rst_n), .en_i(en), .mod_i(beat_mod),
      .pix_i(sink_data[DW-1:0]), .gain_i(act_b_q), .pix_o(source_data[DW-1:0])
   );

   assign source_valid   = vld_p2_q;
   assign source_sop     = sop_p2_q;
   assign source_eop     = eop_p2_q;
   assign slave_readdata = readdata_q;

endmodule

// File: tb/tb_rgb_white_balance.sv
// Self-checking bench for rgb_white_balance: packet-level reference model fed
// from accepted input beats, checked against every beat leaving the source.
module tb_rgb_white_balance;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] sink_data;
   logic        sink_sop, sink_eop, sink_valid, sink_ready;
   logic [23:0] source_data;
   logic        source_sop, source_eop, source_valid, source_ready;
   logic [2:0]  slave_addr;
   logic        slave_write, slave_read;
   logic [31:0] slave_writedata, slave_readdata;

   always #5 clk = ~clk;

   rgb_white_balance #(.DW(8), .GAIN_W(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .sink_data(sink_data), .sink_sop(sink_sop), .sink_eop(sink_eop),
      .sink_valid(sink_valid), .sink_ready(sink_ready),
      .source_data(source_data), .source_sop(source_sop), .source_eop(source_eop),
      .source_valid(source_valid), .source_ready(source_ready),
      .slave_addr(slave_addr), .slave_write(slave_write), .slave_writedata(slave_writedata),
      .slave_read(slave_read), .slave_readdata(slave_readdata)
   );

   typedef struct packed {
      logic [23:0] d;
      logic        sop;
      logic        eop;
   } beat_t;

   typedef struct packed {
      logic [23:0] d;
      logic        sop;
      logic        eop;
      logic        vid;
      int unsigned cyc;
   } exp_t;

   beat_t       stim_q[$];
   exp_t        exp_q[$];
   logic [23:0] out_hist[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   int unsigned acc_cnt = 0;
   bit          acc_n = 0;
   bit          rdy_rand = 0, gap_rand = 0, check_lat = 0;

   // reference model state
   int          m_sh[3], m_act[3];
   bit          m_byp, m_byp_act, m_inpkt, m_vid;
   int          m_fc;
   bit          stalled;
   logic [25:0] stall_snap;
   exp_t        mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] wb_apply(input logic [23:0] pix, input int g0, input int g1, input int g2);
      int          gain[3];
      int          v;
      logic [23:0] r;
      gain = '{g0, g1, g2};
      r = '0;
      for (int i = 0; i < 3; i++) begin
         v = (int'(pix[23-8*i -: 8]) * gain[i] + 128) / 256;
         if (v > 255) v = 255;
         r[23-8*i -: 8] = 8'(v);
      end
      return r;
   endfunction

   // Compare process + model update, all on the falling edge where signals are settled.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         m_inpkt = 0; m_vid = 0; m_byp = 0; m_byp_act = 0; m_fc = 0;
         for (int i = 0; i < 3; i++) begin m_sh[i] = 256; m_act[i] = 256; end
         stalled = 0;
         acc_n = 0;
      end else begin
         if (stalled) begin
            chk("stall_valid", 32'(source_valid), 32'd1);
            chk("stall_hold", 32'({source_sop, source_eop, source_data}), 32'(stall_snap));
         end
         if (source_valid && source_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL spurious_beat: got 0x%0h, required no beat", source_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_data", 32'(source_data), 32'(mon_e.d));
               chk("out_sop_eop", 32'({source_sop, source_eop}), 32'({mon_e.sop, mon_e.eop}));
               if (check_lat) chk("latency", cyc - mon_e.cyc, 32'd2);
               if (mon_e.vid && mon_e.eop) m_fc = (m_fc + 1) & 'hFFFF;
               out_hist.push_back(source_data);
            end
         end
         stalled    = source_valid && !source_ready;
         stall_snap = {source_sop, source_eop, source_data};

         acc_n = sink_valid && sink_ready;
         if (acc_n) begin
            acc_cnt++;
            if (sink_sop) begin
               m_vid = (sink_data[3:0] == 4'h0);
               if (m_vid) begin
                  m_act = m_sh;
                  m_byp_act = m_byp;
               end
               exp_q.push_back('{d: sink_data, sop: 1'b1, eop: sink_eop, vid: m_vid, cyc: cyc});
               m_inpkt = !sink_eop;
            end else begin
               exp_q.push_back('{d: (m_inpkt && m_vid && !m_byp_act) ?
                                    wb_apply(sink_data, m_act[0], m_act[1], m_act[2]) : sink_data,
                                 sop: 1'b0, eop: sink_eop, vid: m_inpkt && m_vid, cyc: cyc});
               if (sink_eop) m_inpkt = 0;
            end
         end
         if (slave_write) begin
            if (slave_addr == 3'd0) m_byp = slave_writedata[1];
            if (slave_addr >= 3'd2 && slave_addr <= 3'd4) m_sh[slave_addr - 3'd2] = int'(slave_writedata[11:0]);
         end
      end
   end

   // Stream driver: holds the head beat until it is accepted.
   always @(posedge clk) begin
      #1;
      if (acc_n && stim_q.size() != 0) void'(stim_q.pop_front());
      acc_n = 0;
      source_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst_n && stim_q.size() != 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
         sink_valid = 1'b1;
         sink_data  = stim_q[0].d;
         sink_sop   = stim_q[0].sop;
         sink_eop   = stim_q[0].eop;
      end else begin
         sink_valid = 1'b0;
         sink_data  = '0;
         sink_sop   = 1'b0;
         sink_eop   = 1'b0;
      end
   end

   task automatic push_beat(input logic [23:0] d, input logic sop, input logic eop);
      stim_q.push_back('{d: d, sop: sop, eop: eop});
   endtask

   task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      slave_addr = a; slave_writedata = d; slave_write = 1'b1;
      @(posedge clk); #1;
      slave_write = 1'b0;
   endtask

   task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      slave_addr = a; slave_read = 1'b1;
      @(posedge clk); #1;
      slave_read = 1'b0;
      d = slave_readdata;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((stim_q.size() != 0 || exp_q.size() != 0 || sink_valid) && n < 5000) begin
         @(negedge clk); n++;
      end
      n_chk++;
      if (n >= 5000) begin
         n_fail++;
         $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size() + stim_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_acc(input int unsigned target);
      int n;
      n = 0;
      while (acc_cnt < target && n < 3000) begin
         @(negedge clk); n++;
      end
      n_chk++;
      if (n >= 3000) begin
         n_fail++;
         $display("FAIL wait_accept: accepted %0d, required %0d", acc_cnt, target);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  rd;
      int unsigned  base;
      int           nbeats;
      sink_data = '0; sink_sop = 0; sink_eop = 0; sink_valid = 0; source_ready = 1;
      slave_addr = '0; slave_write = 0; slave_writedata = '0; slave_read = 0;

      repeat (3) @(negedge clk);
      chk("rst_source_valid", 32'(source_valid), 32'd0);
      chk("rst_sink_ready", 32'(sink_ready), 32'd0);
      chk("rst_readdata", slave_readdata, 32'd0);
      chk("rst_source_data", 32'(source_data), 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;

      mm_read(3'd0, rd); chk("rst_ctrl", rd, 32'd0);
      mm_read(3'd1, rd); chk("rst_status", rd, 32'd0);
      mm_read(3'd2, rd); chk("rst_gain_r", rd, 32'h100);
      mm_read(3'd4, rd); chk("rst_gain_b", rd, 32'h100);
      mm_read(3'd5, rd); chk("rst_frame_cnt", rd, 32'd0);
      mm_write(3'd7, 32'hFFFF_FFFF);
      mm_read(3'd7, rd); chk("unmapped_read", rd, 32'd0);
      @(negedge clk); chk("go0_sink_ready", 32'(sink_ready), 32'd0);

      // basic gains, 2-cycle latency
      mm_write(3'd2, 32'h200); mm_write(3'd3, 32'h100); mm_write(3'd4, 32'h080);
      mm_write(3'd0, 32'h1);
      check_lat = 1; out_hist.delete();
      push_beat(24'h000000, 1, 0); push_beat(24'h406080, 0, 1);
      wait_drain("basic");
      chk("basic_header", 32'(out_hist[0]), 32'h000000);
      chk("basic_pixel", 32'(out_hist[1]), 32'h806040);
      mm_read(3'd5, rd); chk("basic_frame_cnt", rd, 32'd1);

      // saturation and rounding
      mm_write(3'd2, 32'h1FF); mm_write(3'd3, 32'h1FF); mm_write(3'd4, 32'h1FF);
      out_hist.delete();
      push_beat(24'h000000, 1, 0); push_beat(24'hFF0101, 0, 1);
      wait_drain("sat");
      chk("sat_pixel", 32'(out_hist[1]), 32'hFF0202);

      // control packet passes bit-exact
      out_hist.delete();
      push_beat(24'h12345F, 1, 0); push_beat(24'hABCDEF, 0, 0); push_beat(24'h55AA33, 0, 1);
      wait_drain("ctrl_pkt");
      chk("ctrl_beat0", 32'(out_hist[0]), 32'h12345F);
      chk("ctrl_beat1", 32'(out_hist[1]), 32'hABCDEF);
      chk("ctrl_beat2", 32'(out_hist[2]), 32'h55AA33);
      mm_read(3'd5, rd); chk("ctrl_frame_cnt", rd, 32'd2);

      // randomized traffic with backpressure and input gaps
      check_lat = 0; rdy_rand = 1; gap_rand = 1;
      for (int p = 0; p < 12; p++) begin
         mm_write(3'd2, 32'($urandom_range(0, 4095)));
         mm_write(3'd3, 32'($urandom_range(0, 4095)));
         mm_write(3'd4, 32'($urandom_range(0, 4095)));
         mm_write(3'd0, 32'(1 | ($urandom_range(0, 1) << 1)));
         if (p % 4 == 3) push_beat({20'($urandom), 4'($urandom_range(1, 15))}, 1, 0);
         else            push_beat({20'($urandom), 4'h0}, 1, 0);
         for (int i = 0; i < 120; i++) push_beat(24'($urandom), 0, i == 119);
         wait_drain("random");
      end
      rdy_rand = 0; gap_rand = 0;
      mm_read(3'd5, rd);
      chk("random_frame_cnt_model", rd, 32'(m_fc));
      chk("random_frame_cnt", rd, 32'd11);

      // mid-frame gain write, then go cleared mid-packet
      check_lat = 1;
      mm_write(3'd2, 32'h100); mm_write(3'd3, 32'h100); mm_write(3'd4, 32'h100);
      mm_write(3'd0, 32'h1);
      out_hist.delete();
      base = acc_cnt;
      push_beat(24'h000000, 1, 0);
      for (int i = 0; i < 20; i++) push_beat(24'h101010, 0, i == 19);
      wait_acc(base + 8);
      mm_write(3'd2, 32'h300);
      push_beat(24'h000000, 1, 0);
      for (int i = 0; i < 20; i++) push_beat(24'h101010, 0, i == 19);
      wait_acc(base + 29);
      mm_write(3'd0, 32'h0);
      wait_drain("midframe");
      chk("midframe_old_gain", 32'(out_hist[20]), 32'h101010);
      chk("midframe_new_gain", 32'(out_hist[22]), 32'h301010);
      chk("go0_packet_done", 32'(out_hist[41]), 32'h301010);
      push_beat(24'h000000, 1, 0); push_beat(24'h010101, 0, 1);
      repeat (20) @(negedge clk);
      chk("go0_sink_ready_idle", 32'(sink_ready), 32'd0);
      chk("go0_no_accept", 32'(stim_q.size()), 32'd2);
      stim_q.delete();
      repeat (3) @(negedge clk);

      // sop while in packet
      mm_write(3'd0, 32'h1);
      out_hist.delete();
      push_beat(24'h000000, 1, 0); push_beat(24'h203040, 0, 0);
      push_beat(24'h000000, 1, 0); push_beat(24'h102030, 0, 1);
      wait_drain("sop_err");
      chk("sop_err_pixel", 32'(out_hist[3]), 32'h302030);
      mm_read(3'd1, rd); chk("sop_err_status", rd, 32'h2);
      mm_write(3'd1, 32'h2);
      mm_read(3'd1, rd); chk("sop_err_cleared", rd, 32'h0);
      mm_read(3'd5, rd); chk("sop_err_frame_cnt", rd, 32'(m_fc));

      // reset in the middle of a packet
      base = acc_cnt;
      push_beat(24'h000000, 1, 0);
      for (int i = 0; i < 30; i++) push_beat(24'($urandom), 0, i == 29);
      wait_acc(base + 10);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("midrst_source_valid", 32'(source_valid), 32'd0);
      chk("midrst_sink_ready", 32'(sink_ready), 32'd0);
      stim_q.delete(); sink_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #3 rst_n = 1'b1;
      mm_read(3'd5, rd); chk("midrst_frame_cnt", rd, 32'd0);
      mm_read(3'd1, rd); chk("midrst_status", rd, 32'd0);
      mm_read(3'd2, rd); chk("midrst_gain_r", rd, 32'h100);
      mm_write(3'd2, 32'h200); mm_write(3'd0, 32'h1);
      out_hist.delete();
      push_beat(24'h111111, 0, 1);
      push_beat(24'h000000, 1, 0); push_beat(24'h111111, 0, 1);
      wait_drain("post_rst");
      nbeats = out_hist.size();
      chk("post_rst_beats", 32'(nbeats), 32'd3);
      chk("post_rst_no_sop", 32'(out_hist[0]), 32'h111111);
      chk("post_rst_video", 32'(out_hist[2]), 32'h221111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
